// File: rtl/otter_lsu_pkg.sv
// Shared types and helpers for the OTTER load/store unit.
package otter_lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOAD_LO  = 2'd1;
   localparam logic [1:0] ST_LOAD_HI  = 2'd2;
   localparam logic [1:0] ST_STORE_HI = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      LOAD_LO  = ST_LOAD_LO,
      LOAD_HI  = ST_LOAD_HI,
      STORE_HI = ST_STORE_HI
   } lsu_state_e;

   // Bytes touched by an access; 0 marks the illegal size encoding.
   function automatic logic [2:0] size_nbytes(input logic [1:0] size);
      case (size)
         SIZE_B:  size_nbytes = 3'd1;
         SIZE_H:  size_nbytes = 3'd2;
         SIZE_W:  size_nbytes = 3'd4;
         default: size_nbytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// Core-side request/response bundle and memory-side access bundle of the LSU.

// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; resp_valid is a one-cycle pulse with no backpressure.
interface otter_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

interface otter_dmem_if;
   logic        dmem_r_en;
   logic        dmem_w_en;
   logic [3:0]  dmem_w_strb;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_w_data;
   logic [31:0] dmem_r_data;

   modport master (
      output dmem_r_en, dmem_w_en, dmem_w_strb, dmem_addr, dmem_w_data,
      input  dmem_r_data
   );
   modport slave (
      input  dmem_r_en, dmem_w_en, dmem_w_strb, dmem_addr, dmem_w_data,
      output dmem_r_data
   );
endinterface

// File: rtl/otter_lsu_align.sv
// Load data aligner: picks the addressed bytes from a two-word window and extends them.
module otter_lsu_align
   import otter_lsu_pkg::*;
(
   input  logic [63:0] window_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = 32'(window_i >> {off_i, 3'b000});

   always_comb begin
      data_o = shifted;
      case (size_i)
         SIZE_B:  data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
         SIZE_H:  data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: word-aligned strobed memory accesses, load extension,
// and two-beat splitting of accesses that cross a word boundary.
module otter_lsu
   import otter_lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   otter_lsu_if.slave   core,
   otter_dmem_if.master dmem,
   output lsu_state_e   dbg_state_o
);

   lsu_state_e  state_q;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic        span_q;
   logic [31:0] addr_hi_q;
   logic [3:0]  strb_hi_q;
   logic [31:0] wdata_hi_q;
   logic [31:0] lo_data_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [1:0]  req_off;
   logic [2:0]  req_nbytes;
   logic [3:0]  mask_base;
   logic [7:0]  req_mask;
   logic        req_span;
   logic        req_err;
   logic [63:0] req_wide;
   logic [31:0] req_lo_addr;
   logic [31:0] req_hi_addr;
   logic        accept;

   assign req_off     = core.req_addr[1:0];
   assign req_nbytes  = size_nbytes(core.req_size);
   assign req_span    = ({1'b0, req_off} + req_nbytes) > 3'd4;
   assign req_err     = (req_nbytes == 3'd0) || (req_span && !ALLOW_MISALIGNED);
   assign req_wide    = {32'b0, core.req_wdata} << {req_off, 3'b000};
   assign req_lo_addr = {core.req_addr[31:2], 2'b00};
   assign req_hi_addr = req_lo_addr + 32'd4;
   assign req_mask    = {4'b0000, mask_base} << req_off;

   always_comb begin
      mask_base = 4'b0000;
      case (req_nbytes)
         3'd1:    mask_base = 4'b0001;
         3'd2:    mask_base = 4'b0011;
         3'd4:    mask_base = 4'b1111;
         default: mask_base = 4'b0000;
      endcase
   end

   assign core.req_ready = (state_q == IDLE) && rst_n;
   assign accept         = core.req_ready && core.req_valid;

   // A split load merges the saved low word with the word arriving now.
   logic [63:0] window;
   logic [31:0] load_data;

   assign window = (state_q == LOAD_HI) ? {dmem.dmem_r_data, lo_data_q}
                                        : {32'b0, dmem.dmem_r_data};

   otter_lsu_align u_align (
      .window_i   (window),
      .off_i      (off_q),
      .size_i     (size_q),
      .unsigned_i (unsigned_q),
      .data_o     (load_data)
   );

   logic        mem_r_en;
   logic        mem_w_en;
   logic [3:0]  mem_strb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   // First beat comes straight from the request; second beat from captured state.
   always_comb begin
      mem_r_en  = 1'b0;
      mem_w_en  = 1'b0;
      mem_strb  = 4'b0000;
      mem_addr  = 32'b0;
      mem_wdata = 32'b0;
      case (state_q)
         IDLE: begin
            if (accept && !req_err) begin
               mem_r_en  = !core.req_we;
               mem_w_en  = core.req_we;
               mem_strb  = core.req_we ? req_mask[3:0] : 4'b0000;
               mem_addr  = req_lo_addr;
               mem_wdata = core.req_we ? req_wide[31:0] : 32'b0;
            end
         end
         LOAD_LO: begin
            mem_r_en = span_q;
            mem_addr = span_q ? addr_hi_q : 32'b0;
         end
         STORE_HI: begin
            mem_w_en  = 1'b1;
            mem_strb  = strb_hi_q;
            mem_addr  = addr_hi_q;
            mem_wdata = wdata_hi_q;
         end
         default: ;
      endcase
   end

   assign dmem.dmem_r_en   = mem_r_en & rst_n;
   assign dmem.dmem_w_en   = mem_w_en & rst_n;
   assign dmem.dmem_w_strb = mem_strb;
   assign dmem.dmem_addr   = mem_addr;
   assign dmem.dmem_w_data = mem_wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         off_q        <= 2'b0;
         size_q       <= 2'b0;
         unsigned_q   <= 1'b0;
         span_q       <= 1'b0;
         addr_hi_q    <= 32'b0;
         strb_hi_q    <= 4'b0;
         wdata_hi_q   <= 32'b0;
         lo_data_q    <= 32'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'b0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  off_q      <= req_off;
                  size_q     <= core.req_size;
                  unsigned_q <= core.req_unsigned;
                  span_q     <= req_span;
                  addr_hi_q  <= req_hi_addr;
                  strb_hi_q  <= req_mask[7:4];
                  wdata_hi_q <= req_wide[63:32];
                  if (req_err) begin
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'b0;
                  end else if (core.req_we) begin
                     if (req_span) begin
                        state_q <= STORE_HI;
                     end else begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'b0;
                     end
                  end else begin
                     state_q <= LOAD_LO;
                  end
               end
            end
            LOAD_LO: begin
               if (span_q) begin
                  lo_data_q <= dmem.dmem_r_data;
                  state_q   <= LOAD_HI;
               end else begin
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= load_data;
                  state_q      <= IDLE;
               end
            end
            LOAD_HI: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= load_data;
               state_q      <= IDLE;
            end
            STORE_HI: begin
               resp_valid_q <= 1'b1;
               resp_rdata_q <= 32'b0;
               state_q      <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign core.resp_valid = resp_valid_q;
   assign core.resp_err   = resp_err_q;
   assign core.resp_rdata = resp_rdata_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_otter_lsu.sv
// Bench for otter_lsu: directed bus checks plus randomized traffic scored
// against a byte-addressed reference memory.
module tb_otter_lsu;
   import otter_lsu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   otter_lsu_if  ca ();
   otter_dmem_if ma ();
   otter_lsu_if  cb ();
   otter_dmem_if mb ();
   lsu_state_e   state_a;
   lsu_state_e   state_b;

   otter_lsu #(.ALLOW_MISALIGNED(1'b1)) dut_a (
      .clk (clk), .rst_n (rst_n), .core (ca), .dmem (ma), .dbg_state_o (state_a)
   );
   otter_lsu #(.ALLOW_MISALIGNED(1'b0)) dut_b (
      .clk (clk), .rst_n (rst_n), .core (cb), .dmem (mb), .dbg_state_o (state_b)
   );

   assign mb.dmem_r_data = 32'h0;

   function automatic logic [31:0] init_word(input int idx);
      if (idx == 64) return 32'h44332211;
      if (idx == 65) return 32'h88776655;
      return (idx * 32'h01000193) ^ 32'hA5A55A5A;
   endfunction

   // Word memory behind dut_a: 4 KB image, registered read.
   logic [31:0] mem [1024];
   logic        mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else begin
         if (ma.dmem_r_en) ma.dmem_r_data <= mem[ma.dmem_addr[11:2]];
         if (ma.dmem_w_en)
            for (int b = 0; b < 4; b++)
               if (ma.dmem_w_strb[b]) mem[ma.dmem_addr[11:2]][8*b +: 8] <= ma.dmem_w_data[8*b +: 8];
      end
   end

   // Reference model: flat byte array, addresses wrap mod 2^32 (low 12 bits kept).
   logic [7:0]  ref_mem [4096];
   logic [64:0] exp_q[$];
   logic [31:0] last_rdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nbytes_of(input logic [1:0] size);
      case (size)
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 4;
         default: return 0;
      endcase
   endfunction

   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata, output int lat);
      int n;
      int off;
      longint v;
      n     = nbytes_of(size);
      off   = int'(addr[1:0]);
      rdata = 32'h0;
      err   = (n == 0);
      if (err) begin
         lat = 1;
      end else if (we) begin
         for (int k = 0; k < n; k++) ref_mem[12'(addr + k)] = wdata[8*k +: 8];
         lat = (off + n > 4) ? 2 : 1;
      end else begin
         v = 0;
         for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[12'(addr + k)]) << (8 * k));
         if (n < 4 && !uns && v[8*n-1]) v = v | ~((longint'(1) << (8 * n)) - 1);
         rdata = v[31:0];
         lat = (off + n > 4) ? 3 : 2;
      end
   endtask

   // Monitor: pops one expectation per response, checks value and arrival cycle.
   always @(negedge clk) begin
      logic [64:0] e;
      if (rst_n) begin
         if (ca.resp_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp: got resp_valid=1 want 0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("resp_err", {31'b0, ca.resp_err}, {31'b0, e[64]});
               chk("resp_rdata", ca.resp_rdata, e[63:32]);
               chk("resp_cycle", cyc, e[31:0]);
               last_rdata = ca.resp_rdata;
            end
         end else if (exp_q.size() > 0 && cyc > int'(exp_q[0][31:0])) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL resp_missing: got none want response by cycle %0d", e[31:0]);
         end
      end
   end

   task automatic start_a(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
      int guard = 0;
      logic err;
      logic [31:0] rdata;
      int lat;
      while (!ca.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      ok = ca.req_ready;
      if (!ok) begin
         chk("req_ready_timeout", {31'b0, ca.req_ready}, 32'h1);
         return;
      end
      ca.req_valid    = 1'b1;
      ca.req_we       = we;
      ca.req_size     = size;
      ca.req_unsigned = uns;
      ca.req_addr     = addr;
      ca.req_wdata    = wdata;
      model(we, size, uns, addr, wdata, err, rdata, lat);
      exp_q.push_back({err, rdata, 32'(cyc + lat)});
   endtask

   task automatic end_a();
      @(posedge clk);
      @(negedge clk);
      ca.req_valid = 1'b0;
   endtask

   task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bit ok;
      start_a(we, size, uns, addr, wdata, ok);
      if (ok) end_a();
   endtask

   task automatic drain();
      int guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
   endtask

   task automatic load_check(input string name, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] want);
      issue_a(1'b0, size, uns, addr, 32'h0);
      drain();
      chk(name, last_rdata, want);
   endtask

   initial begin
      bit ok;
      logic        r_we;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      for (int a = 0; a < 4096; a++) ref_mem[a] = init_word(a / 4)[8*(a%4) +: 8];
      ca.req_valid = 1'b0; ca.req_we = 1'b0; ca.req_size = 2'd0; ca.req_unsigned = 1'b0;
      ca.req_addr = 32'h0; ca.req_wdata = 32'h0;
      cb.req_valid = 1'b0; cb.req_we = 1'b0; cb.req_size = 2'd0; cb.req_unsigned = 1'b0;
      cb.req_addr = 32'h0; cb.req_wdata = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, ca.req_ready}, 32'h0);
      chk("rst_r_en", {31'b0, ma.dmem_r_en}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_state", {30'b0, state_a}, {30'b0, IDLE});
      chk("rst_resp_valid", {31'b0, ca.resp_valid}, 32'h0);
      chk("rst_resp_rdata", ca.resp_rdata, 32'h0);
      chk("ready_after_rst", {31'b0, ca.req_ready}, 32'h1);

      // Aligned word load: address and read enable in the accept cycle.
      start_a(1'b0, SIZE_W, 1'b0, 32'h100, 32'h0, ok);
      #1;
      chk("lw_r_en", {31'b0, ma.dmem_r_en}, 32'h1);
      chk("lw_addr", ma.dmem_addr, 32'h100);
      end_a();
      drain();
      chk("lw_100", last_rdata, 32'h44332211);

      start_a(1'b0, SIZE_H, 1'b0, 32'h103, 32'h0, ok);
      #1;
      chk("lh_lo_addr", ma.dmem_addr, 32'h100);
      end_a();
      #1;
      chk("lh_hi_r_en", {31'b0, ma.dmem_r_en}, 32'h1);
      chk("lh_hi_addr", ma.dmem_addr, 32'h104);
      drain();
      chk("lh_103", last_rdata, 32'h00005544);

      load_check("lb_107", SIZE_B, 1'b0, 32'h107, 32'hFFFFFF88);
      load_check("lbu_107", SIZE_B, 1'b1, 32'h107, 32'h00000088);

      // Reset during LOAD_LO of a split word load.
      start_a(1'b0, SIZE_W, 1'b0, 32'h102, 32'h0, ok);
      end_a();
      chk("split_lo_state", {30'b0, state_a}, {30'b0, LOAD_LO});
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_r_en", {31'b0, ma.dmem_r_en}, 32'h0);
      chk("mid_rst_state", {30'b0, state_a}, {30'b0, IDLE});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_release", {31'b0, ca.req_ready}, 32'h1);
      repeat (4) @(negedge clk);
      load_check("lw_104_after_rst", SIZE_W, 1'b0, 32'h104, 32'h88776655);

      // Split store across 0x100/0x104.
      start_a(1'b1, SIZE_W, 1'b0, 32'h102, 32'hAABBCCDD, ok);
      #1;
      chk("sw_lo_addr", ma.dmem_addr, 32'h100);
      chk("sw_lo_strb", {28'b0, ma.dmem_w_strb}, 32'hC);
      chk("sw_lo_data", ma.dmem_w_data, 32'hCCDD0000);
      end_a();
      #1;
      chk("sw_hi_w_en", {31'b0, ma.dmem_w_en}, 32'h1);
      chk("sw_hi_addr", ma.dmem_addr, 32'h104);
      chk("sw_hi_strb", {28'b0, ma.dmem_w_strb}, 32'h3);
      chk("sw_hi_data", ma.dmem_w_data, 32'h0000AABB);
      drain();
      load_check("rd_100", SIZE_W, 1'b0, 32'h100, 32'hCCDD2211);
      load_check("rd_104", SIZE_W, 1'b0, 32'h104, 32'h8877AABB);

      // High address wraps to zero at the top of the address space.
      start_a(1'b1, SIZE_W, 1'b0, 32'hFFFFFFFD, 32'h11223344, ok);
      #1;
      chk("wrap_lo_addr", ma.dmem_addr, 32'hFFFFFFFC);
      chk("wrap_lo_strb", {28'b0, ma.dmem_w_strb}, 32'hE);
      end_a();
      #1;
      chk("wrap_hi_addr", ma.dmem_addr, 32'h0);
      chk("wrap_hi_data", ma.dmem_w_data, 32'h00000011);
      drain();
      load_check("wrap_rd", SIZE_W, 1'b0, 32'hFFFFFFFD, 32'h11223344);

      // Misaligned disallowed, and illegal size, on dut_b.
      cb.req_valid = 1'b1; cb.req_we = 1'b0; cb.req_size = SIZE_W; cb.req_addr = 32'h101;
      #1;
      chk("b_mis_no_r_en", {31'b0, mb.dmem_r_en}, 32'h0);
      chk("b_mis_no_w_en", {31'b0, mb.dmem_w_en}, 32'h0);
      @(posedge clk); @(negedge clk);
      chk("b_mis_valid", {31'b0, cb.resp_valid}, 32'h1);
      chk("b_mis_err", {31'b0, cb.resp_err}, 32'h1);
      chk("b_mis_ready", {31'b0, cb.req_ready}, 32'h1);
      cb.req_size = 2'd3; cb.req_addr = 32'h100;
      #1;
      chk("b_ill_no_r_en", {31'b0, mb.dmem_r_en}, 32'h0);
      @(posedge clk); @(negedge clk);
      chk("b_ill_valid", {31'b0, cb.resp_valid}, 32'h1);
      chk("b_ill_err", {31'b0, cb.resp_err}, 32'h1);
      cb.req_size = SIZE_W;
      #1;
      chk("b_ok_r_en", {31'b0, mb.dmem_r_en}, 32'h1);
      @(posedge clk); @(negedge clk);
      cb.req_valid = 1'b0;
      chk("b_ok_pending", {31'b0, cb.resp_valid}, 32'h0);
      @(posedge clk); @(negedge clk);
      chk("b_ok_valid", {31'b0, cb.resp_valid}, 32'h1);
      chk("b_ok_err", {31'b0, cb.resp_err}, 32'h0);

      // Randomized traffic on dut_a, including back-to-back and illegal sizes.
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         r_we   = 1'($urandom_range(0, 1));
         r_size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         r_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 11)
                                             : 32'h100 + $urandom_range(0, 63);
         issue_a(r_we, r_size, 1'($urandom_range(0, 1)), r_addr, $urandom);
      end
      drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL exp_q_empty: got %0d pending want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
